// File: rtl/pc_regfile_core.sv
`default_nettype none
// ============================================================================
// Module      : pc_regfile_core
// Description : Program counter with an enable-gated increment, plus a
//               2**ADDR_WIDTH x DATA_WIDTH register file. The register file
//               has one write port and two asynchronous read ports. Port A
//               shares its select with the write address.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_regfile_core #(
  parameter int PC_WIDTH   = 6,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  controle,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_next,
  input  logic                  Hab_Escrita,
  input  logic [ADDR_WIDTH-1:0] Sel_E_SA,
  input  logic [ADDR_WIDTH-1:0] Sel_SB,
  input  logic [DATA_WIDTH-1:0] E,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Incrementer wraps naturally at 2**PC_WIDTH; the carry is discarded.
  always_comb begin
    pc_next = pc_q + PC_WIDTH'(1);
    pc_d    = controle ? pc_next : pc_q;
  end

  // PC register: cleared asynchronously, advances only when enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

  // Register file storage. Every entry, including entry 0, is writable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (Hab_Escrita) begin
      regs_q[Sel_E_SA] <= E;
    end
  end

  // Reads come straight from storage, with no write-data bypass.
  always_comb begin
    A = regs_q[Sel_E_SA];
    B = regs_q[Sel_SB];
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_regfile_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_regfile_core
// Description : Directed self-checking bench for pc_regfile_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_regfile_core;

  logic        clock;
  logic        reset;
  logic        controle;
  logic [5:0]  pc_out;
  logic [5:0]  pc_next;
  logic        Hab_Escrita;
  logic [2:0]  Sel_E_SA;
  logic [2:0]  Sel_SB;
  logic [15:0] E;
  logic [15:0] A;
  logic [15:0] B;

  int tests_run;
  int tests_failed;

  pc_regfile_core #(
    .PC_WIDTH   (6),
    .DATA_WIDTH (16),
    .ADDR_WIDTH (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .controle    (controle),
    .pc_out      (pc_out),
    .pc_next     (pc_next),
    .Hab_Escrita (Hab_Escrita),
    .Sel_E_SA    (Sel_E_SA),
    .Sel_SB      (Sel_SB),
    .E           (E),
    .A           (A),
    .B           (B)
  );

  // 10 ns clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against the expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    controle     = 1'b0;
    Hab_Escrita  = 1'b0;
    Sel_E_SA     = 3'd0;
    Sel_SB       = 3'd1;
    E            = 16'h0000;

    // Reset state, held across edge at t=5.
    #12;
    check("rst_pc_out",  32'(pc_out),  32'd0);
    check("rst_pc_next", 32'(pc_next), 32'd1);
    check("rst_A",       32'(A),       32'd0);
    check("rst_B",       32'(B),       32'd0);
    reset = 1'b1;

    // The first edge after release has both enables low, so nothing changes.
    step();
    check("idle_pc", 32'(pc_out), 32'd0);

    // PC stepping: 3 enabled edges, then 2 edges with the enable low.
    controle = 1'b1;
    step(); check("step1", 32'(pc_out), 32'd1);
    step(); check("step2", 32'(pc_out), 32'd2);
    step(); check("step3", 32'(pc_out), 32'd3);
    controle = 1'b0;
    step(); check("hold1", 32'(pc_out), 32'd3);
    step(); check("hold2", 32'(pc_out), 32'd3);
    check("pc_next_at3", 32'(pc_next), 32'd4);

    // PC wrap: advance from 3 to 63, then one more edge.
    controle = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("pc_at63",      32'(pc_out),  32'd63);
    check("pc_next_wrap", 32'(pc_next), 32'd0);
    step();
    check("wrap_pc_out",  32'(pc_out),  32'd0);
    check("wrap_pc_next", 32'(pc_next), 32'd1);
    controle = 1'b0;

    // Write then read back on both ports.
    Hab_Escrita = 1'b1;
    Sel_E_SA = 3'd2; E = 16'hBEEF; step();
    Sel_E_SA = 3'd5; E = 16'h8001; step();
    Hab_Escrita = 1'b0;
    Sel_E_SA = 3'd2; Sel_SB = 3'd5; #1;
    check("rd_A_reg2", 32'(A), 32'hBEEF);
    check("rd_B_reg5", 32'(B), 32'h8001);
    check("pc_unmoved", 32'(pc_out), 32'd0);

    // Register 0 is writable and is not tied to zero.
    Hab_Escrita = 1'b1; Sel_E_SA = 3'd0; E = 16'h5A5A; step();
    Hab_Escrita = 1'b0; Sel_SB = 3'd0; #1;
    check("reg0_write", 32'(B), 32'h5A5A);

    // With the write enable low, the edge must not change reg2.
    Sel_E_SA = 3'd2; E = 16'h0000; Hab_Escrita = 1'b0; step();
    check("blocked_A", 32'(A), 32'hBEEF);

    // Read-during-write with both ports selecting reg4.
    Sel_E_SA = 3'd4; Sel_SB = 3'd4; E = 16'h0011; Hab_Escrita = 1'b1; step();
    E = 16'h0022; #1;
    check("rdw_A_before", 32'(A), 32'h0011);
    check("rdw_B_before", 32'(B), 32'h0011);
    step();
    Hab_Escrita = 1'b0;
    check("rdw_A_after", 32'(A), 32'h0022);
    check("rdw_B_after", 32'(B), 32'h0022);

    // PC advance and a register write in the same cycle both take effect.
    controle = 1'b1; Hab_Escrita = 1'b1; Sel_E_SA = 3'd3; E = 16'h1234; step();
    Hab_Escrita = 1'b0;
    check("concurrent_pc",  32'(pc_out), 32'd1);
    check("concurrent_reg", 32'(A),      32'h1234);
    step(); step(); step(); step();
    controle = 1'b0;
    check("pc_at5", 32'(pc_out), 32'd5);

    // Mid-cycle asynchronous reset with the write and advance enables high.
    controle = 1'b1; Hab_Escrita = 1'b1; E = 16'hFFFF;
    #2 reset = 1'b0;
    #1;
    check("async_pc_out",  32'(pc_out),  32'd0);
    check("async_pc_next", 32'(pc_next), 32'd1);
    check("async_reg3",    32'(A),       32'd0);
    Sel_SB = 3'd2; #1;
    check("async_reg2", 32'(B), 32'd0);
    step();
    check("rst_hold_pc",  32'(pc_out), 32'd0);
    check("rst_hold_reg", 32'(A),      32'd0);
    controle = 1'b0; Hab_Escrita = 1'b0;
    reset = 1'b1;
    step();
    check("post_rst_idle", 32'(pc_out), 32'd0);
    controle = 1'b1; step();
    check("post_rst_step", 32'(pc_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
